// File: rtl/exec_ctrl_pkg.sv
// Shared types and encodings for the pipeline execution controller.
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } exec_state_e;

  localparam logic [1:0] CMD_CLR_CNT = 2'b00;
  localparam logic [1:0] CMD_RUN     = 2'b01;
  localparam logic [1:0] CMD_STEP    = 2'b10;
  localparam logic [1:0] CMD_PAUSE   = 2'b11;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

  function automatic logic is_cmd(input logic fire, input logic [1:0] cmd,
                                  input logic [1:0] code);
    return fire && (cmd == code);
  endfunction

endpackage

// File: rtl/exec_cycle_counter.sv
// Saturating cycle counter with synchronous clear (clear beats increment).
module exec_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/pause/drain sequencer for the 5-stage pipeline enables and IF/ID flush.
// Optional PC breakpoint support is built when EXEC_CTRL_BREAKPOINT_EN is defined.
module pipeline_exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int              PIPE_DEPTH  = 5,
  parameter int              OP_SIZE     = 6,
  parameter logic [OP_SIZE-1:0] HALT_OPCODE = OP_SIZE'(HALT_OPCODE_DEFAULT),
  parameter int              CNT_WIDTH   = 32,
  parameter int              PC_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic [OP_SIZE-1:0]   i_if_opcode,
  input  logic                 i_stall,
`ifdef EXEC_CTRL_BREAKPOINT_EN
  input  logic                 i_bp_valid,
  input  logic [PC_WIDTH-1:0]  i_bp_pc,
  input  logic [PC_WIDTH-1:0]  i_pc,
  output logic                 o_bp_hit,
`endif
  output logic                 o_pc_en,
  output logic                 o_pipe_en,
  output logic                 o_flush_if,
  output logic                 o_running,
  output logic                 o_halted,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cycle_cnt
);

  localparam int DRAIN_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH - 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 2);

  exec_state_e        state_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               running_q;
  logic               halted_q;
  logic               done_q;

  logic cmd_fire;
  logic halt_match;
  logic bp_stop;
  logic clr_cnt;

  assign o_cmd_ready = (state_q != ST_DRAIN);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign clr_cnt     = is_cmd(cmd_fire, i_cmd, CMD_CLR_CNT);
  assign halt_match  = ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                       (i_if_opcode == HALT_OPCODE);

`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic first_run_q;
  logic bp_hit_q;

  // First RUN cycle after IDLE is masked so resuming at the breakpoint PC proceeds.
  assign bp_stop  = (state_q == ST_RUN) && !first_run_q && !halt_match &&
                    i_bp_valid && (i_pc == i_bp_pc);
  assign o_bp_hit = bp_hit_q;
`else
  assign bp_stop = 1'b0;
`endif

  always_comb begin
    o_pc_en    = 1'b0;
    o_pipe_en  = 1'b0;
    o_flush_if = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        o_pipe_en = !bp_stop;
        o_pc_en   = !i_stall && !halt_match && !bp_stop;
      end
      ST_STEP: begin
        o_pipe_en = 1'b1;
        o_pc_en   = !i_stall && !halt_match;
      end
      ST_DRAIN: begin
        o_pipe_en  = 1'b1;
        o_flush_if = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
      first_run_q <= 1'b0;
      bp_hit_q    <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
      first_run_q <= 1'b0;
      bp_hit_q    <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (is_cmd(cmd_fire, i_cmd, CMD_RUN)) begin
            state_q     <= ST_RUN;
            running_q   <= 1'b1;
`ifdef EXEC_CTRL_BREAKPOINT_EN
            first_run_q <= 1'b1;
`endif
          end else if (is_cmd(cmd_fire, i_cmd, CMD_STEP)) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (halt_match) begin
            state_q   <= ST_DRAIN;
            drain_q   <= DRAIN_LOAD;
            running_q <= 1'b0;
          end else if (bp_stop) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
            bp_hit_q  <= 1'b1;
`endif
          end else if (is_cmd(cmd_fire, i_cmd, CMD_PAUSE)) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        end
        ST_STEP: begin
          if (halt_match) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            drain_q <= drain_q - DRAIN_W'(1);
          end
        end
        ST_HALTED: ;
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_running = running_q;
  assign o_halted  = halted_q;
  assign o_done    = done_q;

  exec_cycle_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cycle_cnt (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .clr_i (clr_cnt),
    .inc_i (o_pipe_en),
    .cnt_o (o_cycle_cnt)
  );

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed scoreboard bench for pipeline_exec_ctrl (32-bit and 4-bit counter instances).
module tb_pipeline_exec_ctrl;

  localparam logic [1:0] C_CLR   = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_PAUSE = 2'b11;
  localparam logic [5:0] NOP     = 6'h00;
  localparam logic [5:0] HALT    = 6'h3F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [5:0]  opcode = 6'h00;
  logic        stall = 1'b0;
  logic        bp_valid = 1'b0;
  logic [31:0] bp_pc = 32'h0;
  logic [31:0] pc = 32'h0;

  logic        cmd_ready, pc_en, pipe_en, flush_if, running, halted, done, bp_hit;
  logic [31:0] cycle_cnt;
  logic        s_cmd_ready, s_pc_en, s_pipe_en, s_flush_if, s_running, s_halted, s_done, s_bp_hit;
  logic [3:0]  s_cycle_cnt;

  always #5 clk = ~clk;

  pipeline_exec_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(cmd_ready), .i_if_opcode(opcode), .i_stall(stall),
`ifdef EXEC_CTRL_BREAKPOINT_EN
    .i_bp_valid(bp_valid), .i_bp_pc(bp_pc), .i_pc(pc), .o_bp_hit(bp_hit),
`endif
    .o_pc_en(pc_en), .o_pipe_en(pipe_en), .o_flush_if(flush_if),
    .o_running(running), .o_halted(halted), .o_done(done), .o_cycle_cnt(cycle_cnt)
  );

  pipeline_exec_ctrl #(.CNT_WIDTH(4)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(s_cmd_ready), .i_if_opcode(opcode), .i_stall(stall),
`ifdef EXEC_CTRL_BREAKPOINT_EN
    .i_bp_valid(bp_valid), .i_bp_pc(bp_pc), .i_pc(pc), .o_bp_hit(s_bp_hit),
`endif
    .o_pc_en(s_pc_en), .o_pipe_en(s_pipe_en), .o_flush_if(s_flush_if),
    .o_running(s_running), .o_halted(s_halted), .o_done(s_done), .o_cycle_cnt(s_cycle_cnt)
  );

`ifndef EXEC_CTRL_BREAKPOINT_EN
  assign bp_hit   = 1'b0;
  assign s_bp_hit = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        pc_en, pipe_en, flush, rdy, run, halt, done, bp;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_cnt = 0;
  logic [3:0]  exp_cnt4 = 0;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
  endtask

  // One clock of stimulus: drive at negedge, record expectation, compare 2ns later.
  task automatic cyc(input string tag, input bit r, input bit v, input logic [1:0] c,
                     input logic [5:0] op, input bit st,
                     input bit e_pc, input bit e_pipe, input bit e_flush, input bit e_rdy,
                     input bit e_run, input bit e_halt, input bit e_done, input bit e_bp = 1'b0);
    exp_t e;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd = c; opcode = op; stall = st;
    if (r) begin
      exp_cnt  = 0;
      exp_cnt4 = 0;
    end
    sb.push_back('{tag, e_pc, e_pipe, e_flush, e_rdy, e_run, e_halt, e_done, e_bp,
                   exp_cnt, exp_cnt4});
    #2;
    e = sb.pop_front();
    chk(e.tag, "pc_en",     {31'b0, pc_en},     {31'b0, e.pc_en});
    chk(e.tag, "pipe_en",   {31'b0, pipe_en},   {31'b0, e.pipe_en});
    chk(e.tag, "flush_if",  {31'b0, flush_if},  {31'b0, e.flush});
    chk(e.tag, "cmd_ready", {31'b0, cmd_ready}, {31'b0, e.rdy});
    chk(e.tag, "running",   {31'b0, running},   {31'b0, e.run});
    chk(e.tag, "halted",    {31'b0, halted},    {31'b0, e.halt});
    chk(e.tag, "done",      {31'b0, done},      {31'b0, e.done});
    chk(e.tag, "cycle_cnt", cycle_cnt,          e.cnt);
    chk(e.tag, "cnt4",      {28'b0, s_cycle_cnt}, {28'b0, e.cnt4});
`ifdef EXEC_CTRL_BREAKPOINT_EN
    chk(e.tag, "bp_hit",    {31'b0, bp_hit},    {31'b0, e.bp});
`endif
    if (!r) begin
      if (v && (c == C_CLR) && e_rdy) begin
        exp_cnt  = 0;
        exp_cnt4 = 0;
      end else if (e_pipe) begin
        if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 1;
      end
    end
  endtask

  initial begin
    // Reset values, then RUN for 10 cycles
    cyc("reset",     1, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    cyc("run_cmd",   0, 1, C_RUN, NOP, 0,  0,0,0,1,0,0,0);
    for (int i = 0; i < 10; i++)
      cyc("run",     0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0);
    cyc("pause",     0, 1, C_PAUSE, NOP, 0, 1,1,0,1,1,0,0);
    cyc("idle",      0, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    // Single step
    cyc("step_cmd",  0, 1, C_STEP, NOP, 0, 0,0,0,1,0,0,0);
    cyc("step",      0, 0, C_CLR, NOP, 0,  1,1,0,1,0,0,0);
    cyc("post_step", 0, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    cyc("clr_idle",  0, 1, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    cyc("cleared",   0, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    // Stall
    cyc("run_cmd2",  0, 1, C_RUN, NOP, 0,  0,0,0,1,0,0,0);
    for (int i = 0; i < 3; i++)
      cyc("stall",   0, 0, C_CLR, NOP, 1,  0,1,0,1,1,0,0);
    cyc("unstall",   0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0);
    cyc("clr_run",   0, 1, C_CLR, NOP, 0,  1,1,0,1,1,0,0);
    cyc("run_clr",   0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0);
    // HALT beats a same-cycle PAUSE, then drain ignores commands
    cyc("halt",      0, 1, C_PAUSE, HALT, 0, 0,1,0,1,1,0,0);
    cyc("drain_clr", 0, 1, C_CLR, NOP, 0,  0,1,1,0,0,0,0);
    for (int i = 0; i < 3; i++)
      cyc("drain",   0, 0, C_CLR, NOP, 0,  0,1,1,0,0,0,0);
    cyc("done",      0, 1, C_RUN, NOP, 0,  0,0,0,1,0,1,1);
    cyc("halted",    0, 0, C_CLR, NOP, 0,  0,0,0,1,0,1,0);
    cyc("halt_clr",  0, 1, C_CLR, NOP, 0,  0,0,0,1,0,1,0);
    cyc("halt_cnt0", 0, 0, C_CLR, NOP, 0,  0,0,0,1,0,1,0);
`ifdef EXEC_CTRL_BREAKPOINT_EN
    cyc("bp_reset",  1, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    bp_valid = 1'b1; bp_pc = 32'h40; pc = 32'h38;
    cyc("bp_runcmd", 0, 1, C_RUN, NOP, 0,  0,0,0,1,0,0,0, 0);
    pc = 32'h3C;
    cyc("bp_run",    0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0, 0);
    pc = 32'h40;
    cyc("bp_hitcyc", 0, 0, C_CLR, NOP, 0,  0,0,0,1,1,0,0, 0);
    cyc("bp_idle",   0, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0, 1);
    cyc("bp_rerun",  0, 1, C_RUN, NOP, 0,  0,0,0,1,0,0,0, 0);
    cyc("bp_masked", 0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0, 0);
    pc = 32'h44;
    cyc("bp_past",   0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0, 0);
    cyc("bp_norehit",0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0, 0);
    bp_valid = 1'b0;
`endif
    // Saturation on the 4-bit instance, then reset in the middle of DRAIN
    cyc("reset2",    1, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    cyc("run_cmd3",  0, 1, C_RUN, NOP, 0,  0,0,0,1,0,0,0);
    for (int i = 0; i < 20; i++)
      cyc("sat_run", 0, 0, C_CLR, NOP, 0,  1,1,0,1,1,0,0);
    cyc("halt2",     0, 0, C_CLR, HALT, 0, 0,1,0,1,1,0,0);
    cyc("drain2",    0, 0, C_CLR, NOP, 0,  0,1,1,0,0,0,0);
    cyc("drain2",    0, 0, C_CLR, NOP, 0,  0,1,1,0,0,0,0);
    cyc("rst_drain", 1, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    cyc("post_rst",  0, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    cyc("post_rst2", 0, 0, C_CLR, NOP, 0,  0,0,0,1,0,0,0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
